// File: rtl/hazard_scoreboard_pkg.sv
// hazard_pkg: shared widths, bypass encodings and pipeline slot record for the hazard scoreboard.
package hazard_pkg;
  localparam int REG_W = 5;
  localparam int CNT_W = 16;
  localparam logic [REG_W-1:0] ZERO_REG = '0;
  localparam logic [1:0] BYP_RF = 2'b00;
  localparam logic [1:0] BYP_XM = 2'b01;
  localparam logic [1:0] BYP_MW = 2'b10;
  typedef struct packed {
    logic wen;
    logic [REG_W-1:0] rd;
    logic is_load;
  } slot_t;
endpackage

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: decode-side request and scoreboard response bundle.
interface hazard_scoreboard_if;
  import hazard_pkg::*;
  logic d_valid;
  logic [REG_W-1:0] d_rs;
  logic [REG_W-1:0] d_rt;
  logic d_rs_used;
  logic d_rt_used;
  logic [REG_W-1:0] d_rd;
  logic d_wen;
  logic d_is_load;
  logic d_is_md;
  logic md_ready;
  logic stall;
  logic [1:0] byp_a_sel;
  logic [1:0] byp_b_sel;
  logic md_busy;
  logic [REG_W-1:0] md_rd;
  logic [CNT_W-1:0] stall_cycles;
  modport master (
    output d_valid, d_rs, d_rt, d_rs_used, d_rt_used, d_rd, d_wen, d_is_load, d_is_md, md_ready,
    input stall, byp_a_sel, byp_b_sel, md_busy, md_rd, stall_cycles
  );
  modport slave (
    input d_valid, d_rs, d_rt, d_rs_used, d_rt_used, d_rd, d_wen, d_is_load, d_is_md, md_ready,
    output stall, byp_a_sel, byp_b_sel, md_busy, md_rd, stall_cycles
  );
endinterface

// File: rtl/hazard_scoreboard_reg_hit.sv
// reg_hit: register-number match against a writer, never matching register 0.
module reg_hit
  import hazard_pkg::*;
(
  input  logic             wen,
  input  logic [REG_W-1:0] rd,
  input  logic [REG_W-1:0] r,
  output logic             match
);
  assign match = wen & (rd == r) & (r != ZERO_REG);
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: decode/execute stall and operand-bypass control with multdiv tracking.
module hazard_scoreboard
  import hazard_pkg::*;
(
  input logic clock,
  input logic reset_n,
  hazard_scoreboard_if.slave sb
);
  slot_t x_q, m_q, w_q, x_d;
  logic md_busy_q, md_busy_d;
  logic [REG_W-1:0] md_rd_q, md_rd_d;
  logic [1:0] byp_a_q, byp_a_d, byp_b_q, byp_b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [REG_W-1:0] src [2];
  logic [1:0] used, hx, hm, hmd;
  logic waw, load_use, md_raw, stall, issue;
  assign src[0] = sb.d_rs;
  assign src[1] = sb.d_rt;
  assign used = {sb.d_rt_used, sb.d_rs_used};
  for (genvar i = 0; i < 2; i++) begin : g_src
    reg_hit u_hx  (.wen(x_q.wen),   .rd(x_q.rd),  .r(src[i]), .match(hx[i]));
    reg_hit u_hm  (.wen(m_q.wen),   .rd(m_q.rd),  .r(src[i]), .match(hm[i]));
    reg_hit u_hmd (.wen(md_busy_q), .rd(md_rd_q), .r(src[i]), .match(hmd[i]));
  end
  reg_hit u_waw (.wen(md_busy_q & sb.d_wen), .rd(md_rd_q), .r(sb.d_rd), .match(waw));
  always_comb begin
    load_use = x_q.is_load & |(hx & used);
    md_raw = |(hmd & used);
    stall = sb.d_valid & (load_use | md_raw | waw | (md_busy_q & sb.d_is_md));
    issue = sb.d_valid & ~stall;
    x_d = issue ? slot_t'{sb.d_wen & ~sb.d_is_md, sb.d_rd, sb.d_is_load} : '0;
    byp_a_d = ~(issue & used[0]) ? BYP_RF : hx[0] ? BYP_XM : hm[0] ? BYP_MW : BYP_RF;
    byp_b_d = ~(issue & used[1]) ? BYP_RF : hx[1] ? BYP_XM : hm[1] ? BYP_MW : BYP_RF;
    md_busy_d = (issue & sb.d_is_md) ? 1'b1 : sb.md_ready ? 1'b0 : md_busy_q;
    md_rd_d = (issue & sb.d_is_md) ? sb.d_rd : md_rd_q;
    cnt_d = (stall & ~&cnt_q) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      x_q <= '0;
      m_q <= '0;
      w_q <= '0;
      md_busy_q <= 1'b0;
      md_rd_q <= '0;
      byp_a_q <= BYP_RF;
      byp_b_q <= BYP_RF;
      cnt_q <= '0;
    end else begin
      x_q <= x_d;
      m_q <= x_q;
      w_q <= m_q;
      md_busy_q <= md_busy_d;
      md_rd_q <= md_rd_d;
      byp_a_q <= byp_a_d;
      byp_b_q <= byp_b_d;
      cnt_q <= cnt_d;
    end
  end
  assign sb.stall = stall;
  assign sb.byp_a_sel = byp_a_q;
  assign sb.byp_b_sel = byp_b_q;
  assign sb.md_busy = md_busy_q;
  assign sb.md_rd = md_rd_q;
  assign sb.stall_cycles = cnt_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed scenario tasks with hand-computed expectations.
module tb_hazard_scoreboard;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int errs = 0;
  int checks = 0;
  hazard_scoreboard_if sb ();
  hazard_scoreboard dut (.clock(clock), .reset_n(reset_n), .sb(sb));
  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic drv(input logic v, input logic [4:0] rs, input logic ru, input logic [4:0] rt,
                     input logic tu, input logic [4:0] rd, input logic wen, input logic ld,
                     input logic md, input logic rdy);
    sb.d_valid = v; sb.d_rs = rs; sb.d_rs_used = ru; sb.d_rt = rt; sb.d_rt_used = tu;
    sb.d_rd = rd; sb.d_wen = wen; sb.d_is_load = ld; sb.d_is_md = md; sb.md_ready = rdy;
    #1;
  endtask

  task automatic do_reset;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    do_reset();
    drv(1, 0, 0, 0, 0, 5'd4, 1, 0, 1, 0);
    tick();
    drv(1, 5'd4, 1, 0, 0, 5'd6, 1, 0, 0, 0);
    tick();
    reset_n = 1'b0;
    #2;
    checks++;
    if ({sb.stall, sb.byp_a_sel, sb.byp_b_sel, sb.md_busy, sb.md_rd, sb.stall_cycles} !== '0) begin
      errs++;
      $display("FAIL reset_outputs got stall=%0b a=%0d b=%0d busy=%0b md_rd=%0d cnt=%0d exp all 0",
               sb.stall, sb.byp_a_sel, sb.byp_b_sel, sb.md_busy, sb.md_rd, sb.stall_cycles);
    end
    tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    reset_n = 1'b1;
    tick();
    checks++;
    if (sb.md_busy !== 1'b0) begin errs++; $display("FAIL reset_md_ready_ignored got=%0b exp=0", sb.md_busy); end
  endtask

  task automatic test_forward;
    do_reset();
    drv(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0, 0);
    tick();
    drv(1, 5'd5, 1, 5'd5, 0, 5'd8, 1, 0, 0, 0);
    checks++;
    if (sb.stall !== 1'b0) begin errs++; $display("FAIL fwd_xm_nostall got=%0b exp=0", sb.stall); end
    tick();
    checks++;
    if (sb.byp_a_sel !== 2'b01 || sb.byp_b_sel !== 2'b00) begin
      errs++; $display("FAIL fwd_xm_sel got a=%0d b=%0d exp a=1 b=0", sb.byp_a_sel, sb.byp_b_sel);
    end
    drv(1, 5'd1, 1, 5'd2, 1, 5'd6, 1, 0, 0, 0);
    tick();
    drv(1, 0, 0, 0, 0, 5'd3, 0, 0, 0, 0);
    tick();
    drv(1, 5'd2, 1, 5'd6, 1, 5'd7, 1, 0, 0, 0);
    tick();
    checks++;
    if (sb.byp_a_sel !== 2'b00 || sb.byp_b_sel !== 2'b10) begin
      errs++; $display("FAIL fwd_mw_sel got a=%0d b=%0d exp a=0 b=2", sb.byp_a_sel, sb.byp_b_sel);
    end
    drv(1, 5'd7, 1, 5'd6, 1, 5'd9, 1, 0, 0, 0);
    tick();
    checks++;
    if (sb.byp_a_sel !== 2'b01 || sb.byp_b_sel !== 2'b00) begin
      errs++; $display("FAIL fwd_x_over_w got a=%0d b=%0d exp a=1 b=0", sb.byp_a_sel, sb.byp_b_sel);
    end
  endtask

  task automatic test_load_use;
    do_reset();
    drv(1, 5'd1, 1, 0, 0, 5'd7, 1, 1, 0, 0);
    tick();
    drv(1, 5'd2, 1, 5'd7, 1, 5'd8, 1, 0, 0, 0);
    checks++;
    if (sb.stall !== 1'b1) begin errs++; $display("FAIL loaduse_stall got=%0b exp=1", sb.stall); end
    tick();
    checks++;
    if (sb.stall !== 1'b0 || sb.stall_cycles !== 16'd1) begin
      errs++; $display("FAIL loaduse_release got stall=%0b cnt=%0d exp stall=0 cnt=1", sb.stall, sb.stall_cycles);
    end
    tick();
    checks++;
    if (sb.byp_b_sel !== 2'b10 || sb.byp_a_sel !== 2'b00) begin
      errs++; $display("FAIL loaduse_sel got a=%0d b=%0d exp a=0 b=2", sb.byp_a_sel, sb.byp_b_sel);
    end
  endtask

  task automatic test_multdiv;
    do_reset();
    drv(1, 5'd1, 1, 5'd2, 1, 5'd9, 1, 0, 1, 0);
    tick();
    checks++;
    if (sb.md_busy !== 1'b1 || sb.md_rd !== 5'd9) begin
      errs++; $display("FAIL md_issue got busy=%0b rd=%0d exp busy=1 rd=9", sb.md_busy, sb.md_rd);
    end
    drv(1, 0, 0, 0, 0, 5'd9, 1, 0, 0, 0);
    checks++;
    if (sb.stall !== 1'b1) begin errs++; $display("FAIL md_waw got=%0b exp=1", sb.stall); end
    drv(1, 0, 0, 0, 0, 5'd3, 1, 0, 1, 0);
    checks++;
    if (sb.stall !== 1'b1) begin errs++; $display("FAIL md_struct got=%0b exp=1", sb.stall); end
    drv(1, 5'd9, 1, 0, 0, 5'd10, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) tick();
    drv(1, 5'd9, 1, 0, 0, 5'd10, 1, 0, 0, 1);
    checks++;
    if (sb.stall !== 1'b1) begin errs++; $display("FAIL md_ready_cycle_stall got=%0b exp=1", sb.stall); end
    tick();
    drv(1, 5'd9, 1, 0, 0, 5'd10, 1, 0, 0, 0);
    checks++;
    if (sb.stall !== 1'b0 || sb.md_busy !== 1'b0 || sb.md_rd !== 5'd9) begin
      errs++; $display("FAIL md_release got stall=%0b busy=%0b rd=%0d exp 0 0 9", sb.stall, sb.md_busy, sb.md_rd);
    end
    tick();
    checks++;
    if (sb.byp_a_sel !== 2'b00 || sb.stall_cycles !== 16'd11) begin
      errs++; $display("FAIL md_after got a=%0d cnt=%0d exp a=0 cnt=11", sb.byp_a_sel, sb.stall_cycles);
    end
  endtask

  task automatic test_zero_reg;
    do_reset();
    drv(1, 0, 0, 0, 0, 5'd0, 1, 1, 0, 0);
    tick();
    drv(1, 5'd0, 1, 5'd0, 1, 5'd0, 1, 0, 1, 0);
    checks++;
    if (sb.stall !== 1'b0) begin errs++; $display("FAIL r0_load_nostall got=%0b exp=0", sb.stall); end
    tick();
    checks++;
    if (sb.byp_a_sel !== 2'b00 || sb.byp_b_sel !== 2'b00 || sb.md_busy !== 1'b1) begin
      errs++; $display("FAIL r0_sel got a=%0d b=%0d busy=%0b exp 0 0 1", sb.byp_a_sel, sb.byp_b_sel, sb.md_busy);
    end
    drv(1, 5'd0, 1, 5'd0, 1, 5'd0, 1, 0, 0, 0);
    checks++;
    if (sb.stall !== 1'b0) begin errs++; $display("FAIL r0_md_nostall got=%0b exp=0", sb.stall); end
  endtask

  task automatic test_invalid;
    do_reset();
    drv(1, 0, 0, 0, 0, 5'd12, 1, 1, 0, 0);
    tick();
    drv(0, 5'd12, 1, 5'd12, 1, 5'd1, 1, 0, 0, 0);
    checks++;
    if (sb.stall !== 1'b0) begin errs++; $display("FAIL invalid_nostall got=%0b exp=0", sb.stall); end
    tick();
    checks++;
    if (sb.byp_a_sel !== 2'b00 || sb.byp_b_sel !== 2'b00 || sb.stall_cycles !== 16'd0) begin
      errs++; $display("FAIL invalid_sel got a=%0d b=%0d cnt=%0d exp 0 0 0", sb.byp_a_sel, sb.byp_b_sel, sb.stall_cycles);
    end
  endtask

  task automatic test_saturate;
    do_reset();
    drv(1, 0, 0, 0, 0, 5'd4, 1, 0, 1, 0);
    tick();
    drv(1, 5'd4, 1, 0, 0, 5'd5, 1, 0, 0, 0);
    for (int i = 0; i < 65534; i++) tick();
    checks++;
    if (sb.stall_cycles !== 16'hFFFE) begin errs++; $display("FAIL sat_pre got=%h exp=fffe", sb.stall_cycles); end
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (sb.stall_cycles !== 16'hFFFF || sb.stall !== 1'b1) begin
      errs++; $display("FAIL sat_hold got cnt=%h stall=%0b exp ffff 1", sb.stall_cycles, sb.stall);
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_multdiv();
    test_zero_reg();
    test_invalid();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Pipeline hazard scoreboard for the miner's soft processor: sits between decode and execute and consumes 5-bit register-number equality matches to decide stalls and operand bypass. It tracks destination registers of instructions in the X, M and W stages plus one outstanding multiply/divide operation. It drives the decode stall, registered bypass selects for the execute stage, and a saturating stall-cycle performance counter.

## Interface
- REG_W, 5: register-number width
- CNT_W, 16: stall counter width
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- d_valid  in  1  decode holds a valid instruction
- d_rs, d_rt  in  REG_W  source registers
- d_rs_used, d_rt_used  in  1  source actually read
- d_rd  in  REG_W  destination register
- d_wen  in  1  instruction writes d_rd
- d_is_load  in  1  instruction is a load
- d_is_md  in  1  instruction is mult/div
- md_ready  in  1  multdiv result written back this cycle
- stall  out  1  hold fetch/decode, inject bubble into X (combinational)
- byp_a_sel, byp_b_sel  out  2  registered; 00 regfile, 01 X/M latch, 10 M/W latch
- md_busy  out  1  multdiv operation outstanding
- md_rd  out  REG_W  destination of outstanding multdiv
- stall_cycles  out  CNT_W  saturating count of stall cycles

## Operation
- Slots X, M, W each hold {wen, rd, is_load}; "hit(slot, r)" = slot.wen & (slot.rd == r) & (r != 0); register 0 never matches.
- Issue = d_valid & ~stall. On issue, X <= {d_wen & ~d_is_md, d_rd, d_is_load}; otherwise X <= bubble (wen=0). M <= X, W <= M every cycle.
- stall asserted when d_valid and any of:
  - load-use: X.is_load & hit(X, used source);
  - md RAW: md_busy & used source == md_rd & md_rd != 0;
  - md WAW: md_busy & d_wen & d_rd == md_rd & d_rd != 0;
  - structural: md_busy & d_is_md.
- md_busy and md_ready asserted in the same cycle: md hazards still apply that cycle; md_busy clears at the next edge (regfile written, no bypass of md result).
- Issue of d_is_md: md_busy <= 1, md_rd <= d_rd. md_ready while md_busy: md_busy <= 0, md_rd unchanged. md_ready while idle: ignored.
- Bypass (computed for the issuing instruction, registered for its X cycle), per operand r: hit(X, r) -> 01; else hit(M, r) -> 10; else 00. Unused source or no issue -> 00. W-stage matches need no bypass (write-before-read regfile).
- stall_cycles increments on every cycle stall=1, saturates at all-ones.

## Timing
- Reset (async, reset_n=0): X/M/W wen=0, is_load=0, rd=0; md_busy=0; md_rd=0; byp_*_sel=00; stall_cycles=0; stall=0 since slots are empty.
- stall: zero-latency combinational from d_* and current state.
- Load-use stall lasts exactly 1 cycle; following cycle the load is in M and byp sel = 10.
- md stall lasts until the cycle after md_ready.
- Reset mid-stall or mid-multdiv: all state cleared immediately; md_ready arriving afterwards ignored.
- d_valid=0: no stall, bubble into X, bypass 00.

## Structure
- Shared package hazard_pkg: REG_W, ZERO_REG, bypass encodings BYP_RF=2'b00, BYP_XM=2'b01, BYP_MW=2'b10, slot record layout.
- One sub-module reg_hit: inputs wen, slot rd, source r; output match with zero-register qualification; instantiated per slot/operand pair.

## Test plan
- Reset with reset_n=0 mid-stream -> all outputs 0, stall_cycles=0, md_busy=0.
- Issue add rd=5, then sub rs=5 -> no stall, byp_a_sel=01 in sub's X cycle; with one instruction between -> 10.
- Load rd=7, next instruction rt=7 -> stall for 1 cycle, stall_cycles=1, then byp_b_sel=10.
- mult rd=9 issued; add rs=9 follows; md_ready pulses after 10 cycles -> stall held through the md_ready cycle, issue the next cycle, byp_a_sel=00.
- Source or destination r0 against in-flight rd=0 writer -> never stall, bypass 00.
- Force 2^CNT_W+3 stall cycles (long md with dependent op) -> stall_cycles saturates at 16'hFFFF.
